mem_stage: RTL and testbench

- Memory-access stage directly downstream of the execute datapath.
- Consumes the computed address (datapath_out) and store data (str_data). Performs word and byte loads/stores against a variable-latency data memory using a req/ack handshake.
- Drives the regfile load-write port: w_addr_ldr, w_en_ldr, w_data_ldr. w_data_ldr also feeds the datapath forwarding muxes (select 2'b10).
- Stalls upstream while a transaction is outstanding.

---
 rtl/mem_stage.sv | 114 +++++++++++
 tb/tb_mem_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: word/byte loads and stores over a req/ack data-memory port, feeding the regfile load-write port.
// Optional build macro MEM_LDR_ROTATE_EN: unaligned word loads return rdata rotated right by 8*addr[1:0].
module mem_stage #(
   parameter int DADDR_W = 11
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ex_valid,
   input  logic               is_load,
   input  logic               is_store,
   input  logic               is_byte,
   input  logic [31:0]        addr,
   input  logic [31:0]        str_data,
   input  logic [3:0]         rd_addr,
   output logic               stall,
   output logic               mem_req,
   output logic               mem_we,
   output logic [DADDR_W-1:0] mem_addr,
   output logic [3:0]         mem_be,
   output logic [31:0]        mem_wdata,
   input  logic               mem_ack,
   input  logic [31:0]        mem_rdata,
   output logic [3:0]         w_addr_ldr,
   output logic               w_en_ldr,
   output logic [31:0]        w_data_ldr
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state, state_next;
   logic        accept;
   logic        byte_q;
   logic [1:0]  lane_q;
   logic [3:0]  rd_q;
   logic [31:0] ld_fmt;
   logic        unused_addr_bits;

   // Bits above the word-address window wrap around in memory space.
   assign unused_addr_bits = ^addr[31:DADDR_W+2];

   assign accept   = (state == IDLE) && ex_valid && (is_load || is_store);
   assign stall    = (state != IDLE);
   assign mem_req  = (state == ACCESS);
   assign w_en_ldr = (state == RESP);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = ACCESS;
         ACCESS:  if (mem_ack) state_next = mem_we ? IDLE : RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ld_fmt = mem_rdata;
      if (byte_q) begin
         case (lane_q)
            2'd0:    ld_fmt = {24'h0, mem_rdata[7:0]};
            2'd1:    ld_fmt = {24'h0, mem_rdata[15:8]};
            2'd2:    ld_fmt = {24'h0, mem_rdata[23:16]};
            default: ld_fmt = {24'h0, mem_rdata[31:24]};
         endcase
      end else begin
`ifdef MEM_LDR_ROTATE_EN
         case (lane_q)
            2'd0:    ld_fmt = mem_rdata;
            2'd1:    ld_fmt = {mem_rdata[7:0],  mem_rdata[31:8]};
            2'd2:    ld_fmt = {mem_rdata[15:0], mem_rdata[31:16]};
            default: ld_fmt = {mem_rdata[23:0], mem_rdata[31:24]};
         endcase
`else
         ld_fmt = mem_rdata;
`endif
      end
   end

   // Request fields are captured at accept and held until ack; a simultaneous
   // load+store is treated as a store. Load results persist for forwarding.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_be     <= 4'h0;
         mem_wdata  <= 32'h0;
         byte_q     <= 1'b0;
         lane_q     <= 2'd0;
         rd_q       <= 4'h0;
         w_addr_ldr <= 4'h0;
         w_data_ldr <= 32'h0;
      end else begin
         if (accept) begin
            mem_we    <= is_store;
            mem_addr  <= addr[DADDR_W+1:2];
            mem_be    <= is_byte ? (4'b0001 << addr[1:0]) : 4'hF;
            mem_wdata <= is_byte ? {4{str_data[7:0]}} : str_data;
            byte_q    <= is_byte;
            lane_q    <= addr[1:0];
            rd_q      <= rd_addr;
         end
         if ((state == ACCESS) && mem_ack && !mem_we) begin
            w_data_ldr <= ld_fmt;
            w_addr_ldr <= rd_q;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage: expected memory requests and regfile writes are queued at stimulus time.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, is_load, is_store, is_byte;
   logic [31:0] addr, str_data;
   logic [3:0]  rd_addr;
   logic        stall, mem_req, mem_we;
   logic [10:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [3:0]  w_addr_ldr;
   logic        w_en_ldr;
   logic [31:0] w_data_ldr;

   int checks = 0;
   int errors = 0;
   int acks   = 0;
   int acks_start;

   typedef struct {logic we; logic [10:0] maddr; logic [3:0] be; logic [31:0] wdata;} mem_exp_t;
   typedef struct {logic [3:0] rd; logic [31:0] data;} wr_exp_t;
   mem_exp_t mem_q[$];
   wr_exp_t  wr_q[$];

   mem_stage #(.DADDR_W(11)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .is_load(is_load), .is_store(is_store),
      .is_byte(is_byte), .addr(addr), .str_data(str_data), .rd_addr(rd_addr),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .w_addr_ldr(w_addr_ldr), .w_en_ldr(w_en_ldr), .w_data_ldr(w_data_ldr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_req && mem_ack) acks++;

   function automatic logic [31:0] loadModel(input logic [31:0] a, input logic byt, input logic [31:0] rdata);
      logic [63:0] dbl;
      if (byt) return (rdata >> (8 * a[1:0])) & 32'h0000_00FF;
`ifdef MEM_LDR_ROTATE_EN
      dbl = {rdata, rdata} >> (8 * a[1:0]);
      return dbl[31:0];
`else
      dbl = '0;
      return rdata;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drives one op (caller sits at a negedge) and queues what the DUT must produce.
   task automatic applyStimulus(input logic ld, input logic st, input logic byt, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] rd, input logic [31:0] rdata);
      mem_exp_t m;
      wr_exp_t  w;
      ex_valid = 1'b1; is_load = ld; is_store = st; is_byte = byt;
      addr = a; str_data = d; rd_addr = rd;
      m.we    = st;
      m.maddr = a[12:2];
      m.be    = byt ? (4'b0001 << a[1:0]) : 4'hF;
      m.wdata = byt ? {d[7:0], d[7:0], d[7:0], d[7:0]} : d;
      mem_q.push_back(m);
      if (!st) begin
         w.rd   = rd;
         w.data = loadModel(a, byt, rdata);
         wr_q.push_back(w);
      end
   endtask

   // Called at the negedge of the first ACCESS cycle; answers after 'delay' wait states.
   task automatic serviceOp(input string tag, input int delay, input logic [31:0] rdata);
      mem_exp_t m;
      wr_exp_t  w;
      m = mem_q.pop_front();
      checkOutput({tag, "_req"}, {31'h0, mem_req}, 32'h1);
      checkOutput({tag, "_stall"}, {31'h0, stall}, 32'h1);
      checkOutput({tag, "_we"}, {31'h0, mem_we}, {31'h0, m.we});
      checkOutput({tag, "_maddr"}, {21'h0, mem_addr}, {21'h0, m.maddr});
      if (m.we) begin
         checkOutput({tag, "_be"}, {28'h0, mem_be}, {28'h0, m.be});
         checkOutput({tag, "_wdata"}, mem_wdata, m.wdata);
      end
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         checkOutput({tag, "_hold_req"}, {31'h0, mem_req}, 32'h1);
         checkOutput({tag, "_hold_maddr"}, {21'h0, mem_addr}, {21'h0, m.maddr});
      end
      mem_ack = 1'b1; mem_rdata = rdata;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
      if (m.we) begin
         checkOutput({tag, "_req_drop"}, {31'h0, mem_req}, 32'h0);
         checkOutput({tag, "_stall_drop"}, {31'h0, stall}, 32'h0);
         checkOutput({tag, "_no_wen"}, {31'h0, w_en_ldr}, 32'h0);
      end else begin
         w = wr_q.pop_front();
         checkOutput({tag, "_wen"}, {31'h0, w_en_ldr}, 32'h1);
         checkOutput({tag, "_waddr"}, {28'h0, w_addr_ldr}, {28'h0, w.rd});
         checkOutput({tag, "_wdata_ldr"}, w_data_ldr, w.data);
         checkOutput({tag, "_resp_stall"}, {31'h0, stall}, 32'h1);
         @(negedge clk);
         checkOutput({tag, "_wen_drop"}, {31'h0, w_en_ldr}, 32'h0);
         checkOutput({tag, "_stall_end"}, {31'h0, stall}, 32'h0);
      end
   endtask

   task automatic runOp(input string tag, input logic ld, input logic st, input logic byt,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] rd,
                        input int delay, input logic [31:0] rdata);
      @(negedge clk);
      applyStimulus(ld, st, byt, a, d, rd, rdata);
      checkOutput({tag, "_accept_stall"}, {31'h0, stall}, 32'h0);
      @(negedge clk);
      ex_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
      serviceOp(tag, delay, rdata);
   endtask

   initial begin
      rst = 1'b1; ex_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; is_byte = 1'b0;
      addr = 32'h0; str_data = 32'h0; rd_addr = 4'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_stall", {31'h0, stall}, 32'h0);
      checkOutput("rst_req", {31'h0, mem_req}, 32'h0);
      checkOutput("rst_we", {31'h0, mem_we}, 32'h0);
      checkOutput("rst_maddr", {21'h0, mem_addr}, 32'h0);
      checkOutput("rst_be", {28'h0, mem_be}, 32'h0);
      checkOutput("rst_wdata", mem_wdata, 32'h0);
      checkOutput("rst_wen", {31'h0, w_en_ldr}, 32'h0);
      checkOutput("rst_waddr", {28'h0, w_addr_ldr}, 32'h0);
      checkOutput("rst_wdata_ldr", w_data_ldr, 32'h0);

      runOp("st_word", 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h1234_5678, 4'h0, 0, 32'h0);
      runOp("ld_word", 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 4'h3, 3, 32'hCAFE_F00D);
      repeat (5) @(negedge clk);
      checkOutput("ld_word_persist", w_data_ldr, 32'hCAFE_F00D);
      checkOutput("ld_waddr_persist", {28'h0, w_addr_ldr}, 32'h3);

      runOp("st_byte", 1'b0, 1'b1, 1'b1, 32'h0000_0013, 32'hA5C3_E15A, 4'h0, 1, 32'h0);
      runOp("ld_byte", 1'b1, 1'b0, 1'b1, 32'h0000_0011, 32'h0, 4'h7, 0, 32'h1122_3344);
      checkOutput("ld_byte_const", w_data_ldr, 32'h0000_0033);
      runOp("ld_unal", 1'b1, 1'b0, 1'b0, 32'h0000_0041, 32'h0, 4'hF, 0, 32'hAABB_CCDD);
      runOp("both_st", 1'b1, 1'b1, 1'b0, 32'hFFFF_E00C, 32'h0BAD_F00D, 4'h2, 2, 32'h0);
      checkOutput("both_st_keep_ldr", w_data_ldr, loadModel(32'h41, 1'b0, 32'hAABB_CCDD));

      @(negedge clk);
      ex_valid = 1'b1; is_load = 1'b0; is_store = 1'b0; mem_ack = 1'b1;
      @(negedge clk);
      checkOutput("ignore_stall", {31'h0, stall}, 32'h0);
      checkOutput("ignore_req", {31'h0, mem_req}, 32'h0);
      checkOutput("ignore_wen", {31'h0, w_en_ldr}, 32'h0);
      ex_valid = 1'b0; mem_ack = 1'b0;

      // Back-to-back: ex_valid stays high, the store waits behind the load.
      @(negedge clk);
      acks_start = acks;
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h5, 32'h0102_0304);
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0104, 32'h5566_7788, 4'h0, 32'h0);
      begin
         mem_exp_t m;
         wr_exp_t  w;
         m = mem_q.pop_front();
         checkOutput("b2b_ld_we", {31'h0, mem_we}, {31'h0, m.we});
         checkOutput("b2b_ld_maddr", {21'h0, mem_addr}, {21'h0, m.maddr});
         mem_ack = 1'b1; mem_rdata = 32'h0102_0304;
         @(negedge clk);
         mem_ack = 1'b0;
         w = wr_q.pop_front();
         checkOutput("b2b_ld_wen", {31'h0, w_en_ldr}, 32'h1);
         checkOutput("b2b_ld_wdata", w_data_ldr, w.data);
         checkOutput("b2b_resp_stall", {31'h0, stall}, 32'h1);
         @(negedge clk);
         checkOutput("b2b_idle_req", {31'h0, mem_req}, 32'h0);
         checkOutput("b2b_idle_stall", {31'h0, stall}, 32'h0);
         @(negedge clk);
         ex_valid = 1'b0; is_store = 1'b0;
         m = mem_q.pop_front();
         checkOutput("b2b_st_req", {31'h0, mem_req}, 32'h1);
         checkOutput("b2b_st_we", {31'h0, mem_we}, {31'h0, m.we});
         checkOutput("b2b_st_maddr", {21'h0, mem_addr}, {21'h0, m.maddr});
         checkOutput("b2b_st_wdata", mem_wdata, m.wdata);
         mem_ack = 1'b1;
         @(negedge clk);
         mem_ack = 1'b0;
         checkOutput("b2b_st_done", {31'h0, stall}, 32'h0);
         repeat (2) @(negedge clk);
         checkOutput("b2b_ack_count", acks - acks_start, 32'd2);
      end

      // Reset during ACCESS of a load abandons it.
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'h9, 32'h7777_7777);
      @(negedge clk);
      ex_valid = 1'b0; is_load = 1'b0;
      void'(mem_q.pop_front());
      wr_q.delete();
      checkOutput("rstmid_req_before", {31'h0, mem_req}, 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rstmid_req", {31'h0, mem_req}, 32'h0);
      checkOutput("rstmid_stall", {31'h0, stall}, 32'h0);
      checkOutput("rstmid_wdata_ldr", w_data_ldr, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("rstmid_no_wen", {31'h0, w_en_ldr}, 32'h0);
      end
      runOp("post_rst_st", 1'b0, 1'b1, 1'b1, 32'h0000_0302, 32'h0000_00C7, 4'h0, 0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
